hs32_decode_stage: RTL and testbench

HS32_DECODE_STAGE -- requirements
Module: hs32_decode_stage

---
 rtl/hs32_pkg.sv | 57 +++++
 rtl/hs32_skid2.sv | 83 ++++++++
 rtl/hs32_decode_stage.sv | 100 ++++++++++
 tb/tb_hs32_decode_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_pkg.sv
// Shared types and helpers for the HS32 decode stage: instruction/packet layouts,
// FIFO state encoding, immediate sign extension and the defined-opcode map.
package hs32_pkg;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [4:0]  sh;
    logic [1:0]  dir;
    logic [15:0] imm;
  } hs32_instr;

  typedef struct packed {
    logic [4:0]  opc;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [31:0] d2;
    logic [4:0]  shl;
    logic [4:0]  shr;
    logic        sext;
    logic        maskl;
    logic        maskr;
  } hs32_s1pkt;

  typedef struct packed {
    logic      ud;
    hs32_s1pkt pkt;
  } hs32_s1ent;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } hs32_fifo_st_e;

  function automatic logic [31:0] sext32(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Returns 1 for opcodes outside the defined instruction map.
  function automatic logic hs32_ud(input logic [5:0] op);
    logic ud;
    casez (op)
      6'b0?_10??: ud = 1'b0;
      6'b00_000?: ud = 1'b0;
      6'b1?_0???: ud = 1'b0;
      6'b1?_1010: ud = 1'b0;
      6'b1?_1100: ud = 1'b0;
      6'b01_0000: ud = 1'b0;
      default:    ud = 1'b1;
    endcase
    return ud;
  endfunction

endpackage

// File: rtl/hs32_skid2.sv
// Two-entry in-order packet buffer (EMPTY/ONE/FULL) with registered head output.
// flush_i empties the buffer and wins over any push or pop in the same cycle.
module hs32_skid2
  import hs32_pkg::*;
#(
  parameter type T = logic [0:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output logic full_o,
  output logic valid_o,
  output T     dout_o
);

  hs32_fifo_st_e state_q, state_d;
  T head_q, head_d;
  T tail_q, tail_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push_i) state_d = ST_ONE; else state_d = ST_EMPTY;
        ST_ONE: begin
          if (push_i && !pop_i)      state_d = ST_FULL;
          else if (pop_i && !push_i) state_d = ST_EMPTY;
          else                       state_d = ST_ONE;
        end
        ST_FULL:  if (pop_i) state_d = ST_ONE; else state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Head always holds the oldest packet; simultaneous push/pop in ONE replaces it.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (state_q)
      ST_EMPTY: if (push_i) head_d = din_i; else head_d = head_q;
      ST_ONE: begin
        if (push_i && pop_i) head_d = din_i;
        else if (push_i)     tail_d = din_i;
        else                 head_d = head_q;
      end
      ST_FULL:  if (pop_i) head_d = tail_q; else head_d = head_q;
      default:  head_d = head_q;
    endcase
  end

  always_comb begin
    valid_o = 1'b0;
    full_o  = 1'b0;
    case (state_q)
      ST_ONE:  valid_o = 1'b1;
      ST_FULL: begin
        valid_o = 1'b1;
        full_o  = 1'b1;
      end
      default: valid_o = 1'b0;
    endcase
    dout_o = head_q;
  end

endmodule

// File: rtl/hs32_decode_stage.sv
// HS32 decode stage: combinational decode + hazard detection feeding a 2-entry buffer.
// Define HS32_DECODE_FWD_EN to add fwd_i/fwdv_i and resolve hazards by forwarding.
module hs32_decode_stage
  import hs32_pkg::*;
#(
  parameter int NSTG = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  hs32_instr              data_i,
  output logic [3:0]             rp_addr_o,
  input  logic [31:0]            rp_data_i,
  input  logic [4*NSTG-1:0]      rd_i,
  input  logic [NSTG-1:0]        stl_i,
`ifdef HS32_DECODE_FWD_EN
  input  logic [32*NSTG-1:0]     fwd_i,
  input  logic [NSTG-1:0]        fwdv_i,
`endif
  input  logic                   flush_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output hs32_s1pkt              data_o,
  output logic                   ud_o
);

  logic        hazard_s;
  logic        fwd_hit_s;
  logic [31:0] fwd_data_s;
  logic        full_s;
  logic        push_s;
  logic        pop_s;
  hs32_s1pkt   pkt_s;
  hs32_s1ent   ent_in_s;
  hs32_s1ent   ent_out_s;

  // Descending scan so the lowest matching stage supplies the forwarded value.
  always_comb begin
    hazard_s   = 1'b0;
    fwd_hit_s  = 1'b0;
    fwd_data_s = 32'h0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (data_i.opcode[4] && (rd_i[4*k +: 4] == data_i.rn) && stl_i[k]) begin
`ifdef HS32_DECODE_FWD_EN
        if (fwdv_i[k]) begin
          fwd_hit_s  = 1'b1;
          fwd_data_s = fwd_i[32*k +: 32];
        end else begin
          hazard_s = 1'b1;
        end
`else
        hazard_s = 1'b1;
`endif
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  always_comb begin
    pkt_s       = '0;
    pkt_s.opc   = {data_i.opcode[5], data_i.opcode[3:0]};
    pkt_s.rd    = data_i.rd;
    pkt_s.rm    = data_i.rm;
    if (data_i.opcode[4]) begin
      pkt_s.d2 = fwd_hit_s ? fwd_data_s : rp_data_i;
    end else begin
      pkt_s.d2 = sext32(data_i.imm);
    end
    pkt_s.shl   = data_i.sh;
    pkt_s.shr   = (data_i.dir == 2'b11) ? (5'd0 - data_i.sh) : data_i.sh;
    pkt_s.sext  = (data_i.dir == 2'b10);
    pkt_s.maskl = !(data_i.dir == 2'b11);
    pkt_s.maskr = |data_i.dir;
    ent_in_s     = '0;
    ent_in_s.ud  = hs32_ud(data_i.opcode);
    ent_in_s.pkt = pkt_s;
  end

  assign rp_addr_o = data_i.rn;
  assign ready_o   = !full_s && !hazard_s && !flush_i;
  assign push_s    = valid_i && ready_o;
  assign pop_s     = valid_o && ready_i;
  assign data_o    = ent_out_s.pkt;
  assign ud_o      = ent_out_s.ud;

  hs32_skid2 #(.T(hs32_s1ent)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .push_i  (push_s),
    .din_i   (ent_in_s),
    .pop_i   (pop_s),
    .full_o  (full_s),
    .valid_o (valid_o),
    .dout_o  (ent_out_s)
  );

endmodule

// File: tb/tb_hs32_decode_stage.sv
// Directed-vector bench for hs32_decode_stage with hand-computed expectations.
module tb_hs32_decode_stage;
  import hs32_pkg::*;

  localparam int NSTG = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_i;
  logic              ready_o;
  hs32_instr         data_i;
  logic [3:0]        rp_addr_o;
  logic [31:0]       rp_data_i;
  logic [4*NSTG-1:0] rd_i;
  logic [NSTG-1:0]   stl_i;
`ifdef HS32_DECODE_FWD_EN
  logic [32*NSTG-1:0] fwd_i;
  logic [NSTG-1:0]    fwdv_i;
`endif
  logic              flush_i;
  logic              valid_o;
  logic              ready_i;
  hs32_s1pkt         data_o;
  logic              ud_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  hs32_decode_stage #(.NSTG(NSTG)) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .rp_addr_o (rp_addr_o),
    .rp_data_i (rp_data_i),
    .rd_i      (rd_i),
    .stl_i     (stl_i),
`ifdef HS32_DECODE_FWD_EN
    .fwd_i     (fwd_i),
    .fwdv_i    (fwdv_i),
`endif
    .flush_i   (flush_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .ud_o      (ud_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic hs32_instr mk(input logic [5:0] op, input logic [3:0] rd, input logic [3:0] rm,
                                   input logic [3:0] rn, input logic [4:0] sh, input logic [1:0] dir,
                                   input logic [15:0] imm);
    hs32_instr i;
    i = '0;
    i.opcode = op; i.rd = rd; i.rm = rm; i.rn = rn; i.sh = sh; i.dir = dir; i.imm = imm;
    return i;
  endfunction

  logic [5:0] ops    [12] = '{6'b010000, 6'b010001, 6'b000001, 6'b000010, 6'b001011, 6'b011011,
                              6'b100111, 6'b111010, 6'b101100, 6'b101110, 6'b110110, 6'b011100};
  logic       ud_exp [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; valid_i = 1'b0; data_i = '0; rp_data_i = 32'h0; rd_i = '0; stl_i = '0;
    flush_i = 1'b0; ready_i = 1'b1;
`ifdef HS32_DECODE_FWD_EN
    fwd_i = '0; fwdv_i = '0;
`endif
    #2;
    check("rst_valid", {63'd0, valid_o}, 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_ud", {63'd0, ud_o}, 64'd0);
    #10 reset = 1'b0;
    tick();

    // Basic register-form accept, 1-cycle latency
    data_i = mk(6'b010000, 4'd1, 4'd2, 4'd3, 5'd0, 2'b00, 16'h0);
    rp_data_i = 32'h1234; valid_i = 1'b1; ready_i = 1'b1;
    #1;
    check("rp_addr", {60'd0, rp_addr_o}, 64'd3);
    check("ready_empty", {63'd0, ready_o}, 64'd1);
    tick();
    valid_i = 1'b0;
    check("lat_valid", {63'd0, valid_o}, 64'd1);
    check("lat_d2", {32'd0, data_o.d2}, 64'h1234);
    check("lat_ud", {63'd0, ud_o}, 64'd0);
    check("lat_rd", {60'd0, data_o.rd}, 64'd1);
    check("lat_rm", {60'd0, data_o.rm}, 64'd2);
    tick();
    check("drain_valid", {63'd0, valid_o}, 64'd0);

    // Immediate form ignores matching stalled stages; imm sign-extended
    data_i = mk(6'b001000, 4'd4, 4'd5, 4'd3, 5'd0, 2'b00, 16'h8001);
    rd_i = {4'd3, 4'd3}; stl_i = 2'b11; valid_i = 1'b1;
    #1;
    check("imm_nohaz", {63'd0, ready_o}, 64'd1);
    tick();
    valid_i = 1'b0;
    check("imm_d2", {32'd0, data_o.d2}, 64'hFFFF8001);
    check("imm_opc", {59'd0, data_o.opc}, 64'h08);
    check("imm_maskr", {63'd0, data_o.maskr}, 64'd0);
    tick();

    // Stage-0 match stalls
    data_i = mk(6'b010000, 4'd6, 4'd0, 4'd3, 5'd0, 2'b00, 16'h0);
    rd_i = {4'd0, 4'd3}; stl_i = 2'b01;
    #1;
    check("haz_k0", {63'd0, ready_o}, 64'd0);

    // Stage-1 match stalls until stl_i clears
    rp_data_i = 32'hCAFE0003; rd_i = {4'd3, 4'd7}; stl_i = 2'b10; valid_i = 1'b1;
    #1;
    check("haz_k1", {63'd0, ready_o}, 64'd0);
    tick();
    check("haz_nopush", {63'd0, valid_o}, 64'd0);
    stl_i = 2'b00;
    #1;
    check("haz_clear", {63'd0, ready_o}, 64'd1);
    tick();
    valid_i = 1'b0;
    check("haz_valid", {63'd0, valid_o}, 64'd1);
    check("haz_d2", {32'd0, data_o.d2}, 64'hCAFE0003);
    tick();
    rd_i = '0;

    // Fill with ready_i=0, third push refused, drain in order
    ready_i = 1'b0; valid_i = 1'b1;
    data_i = mk(6'b010000, 4'd1, 4'd0, 4'd2, 5'd0, 2'b00, 16'h0); rp_data_i = 32'hA;
    tick();
    data_i = mk(6'b010000, 4'd2, 4'd0, 4'd2, 5'd0, 2'b00, 16'h0); rp_data_i = 32'hB;
    #1;
    check("fill_rdy2", {63'd0, ready_o}, 64'd1);
    tick();
    data_i = mk(6'b010000, 4'd9, 4'd0, 4'd2, 5'd0, 2'b00, 16'h0); rp_data_i = 32'hC;
    #1;
    check("full_rdy", {63'd0, ready_o}, 64'd0);
    tick();
    valid_i = 1'b0;
    check("stable_rd", {60'd0, data_o.rd}, 64'd1);
    check("stable_d2", {32'd0, data_o.d2}, 64'hA);
    ready_i = 1'b1;
    tick();
    check("ord2_rd", {60'd0, data_o.rd}, 64'd2);
    check("ord2_d2", {32'd0, data_o.d2}, 64'hB);
    tick();
    check("ord_empty", {63'd0, valid_o}, 64'd0);

    // Streaming push+pop: opcode map, opc field, dir=10 controls
    for (int i = 0; i < 12; i++) begin
      data_i = mk(ops[i], 4'd0, 4'd0, 4'd1, i[4:0], 2'b10, 16'h0);
      valid_i = 1'b1;
      tick();
      check($sformatf("ud_%0d", i), {63'd0, ud_o}, {63'd0, ud_exp[i]});
      check($sformatf("opc_%0d", i), {59'd0, data_o.opc}, {59'd0, ops[i][5], ops[i][3:0]});
      check($sformatf("shr_%0d", i), {59'd0, data_o.shr}, 64'(i));
    end
    check("dir10_sext", {61'd0, data_o.sext, data_o.maskl, data_o.maskr}, 64'b111);
    valid_i = 1'b0;
    tick();

    // Undefined opcode, right-shift amount negated
    data_i = mk(6'b010001, 4'd0, 4'd0, 4'd1, 5'd5, 2'b11, 16'h0); valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("ud1_valid", {63'd0, valid_o}, 64'd1);
    check("ud1_ud", {63'd0, ud_o}, 64'd1);
    check("ud1_shr", {59'd0, data_o.shr}, 64'd27);
    check("ud1_shl", {59'd0, data_o.shl}, 64'd5);
    check("ud1_maskl", {63'd0, data_o.maskl}, 64'd0);
    tick();

    // Flush while FULL with a pending push
    ready_i = 1'b0; valid_i = 1'b1;
    data_i = mk(6'b010000, 4'd1, 4'd0, 4'd2, 5'd0, 2'b00, 16'h0);
    tick(); tick();
    flush_i = 1'b1;
    #1;
    check("flush_rdy", {63'd0, ready_o}, 64'd0);
    tick();
    flush_i = 1'b0; valid_i = 1'b0;
    check("flush_valid", {63'd0, valid_o}, 64'd0);
    ready_i = 1'b1;
    tick();
    check("flush_stay", {63'd0, valid_o}, 64'd0);

    // Reset mid-transfer discards buffered packet
    ready_i = 1'b0; valid_i = 1'b1; rp_data_i = 32'h55;
    tick();
    valid_i = 1'b0;
    check("pre_rst_valid", {63'd0, valid_o}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {63'd0, valid_o}, 64'd0);
    check("arst_data", 64'(data_o), 64'd0);
    #1 reset = 1'b0;
    ready_i = 1'b1;
    tick(); tick();
    check("post_rst", {63'd0, valid_o}, 64'd0);

`ifdef HS32_DECODE_FWD_EN
    data_i = mk(6'b010000, 4'd1, 4'd0, 4'd3, 5'd0, 2'b00, 16'h0);
    rp_data_i = 32'h1111; rd_i = {4'd0, 4'd3}; stl_i = 2'b01; fwdv_i = 2'b01;
    fwd_i = {32'h0, 32'hDEAD}; valid_i = 1'b1;
    #1;
    check("fwd_rdy", {63'd0, ready_o}, 64'd1);
    tick();
    rd_i = {4'd3, 4'd3}; stl_i = 2'b11; fwdv_i = 2'b11; fwd_i = {32'hBEEF, 32'hF00D};
    check("fwd_d2", {32'd0, data_o.d2}, 64'hDEAD);
    tick();
    valid_i = 1'b0;
    check("fwd_low_k", {32'd0, data_o.d2}, 64'hF00D);
    fwdv_i = 2'b01;
    #1;
    check("fwd_partial", {63'd0, ready_o}, 64'd0);
    tick();
    stl_i = '0; fwdv_i = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
